// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load-data extraction/extension, GPR write
// port drive, EX forwarding tap, retired-instruction counter and
// misaligned-load error reporting.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             mem_valid,
  input  logic [31:0]      mem_pc,
  input  logic [31:0]      mem_ins,
  input  logic             mem_we,
  input  logic [4:0]       mem_dst,
  input  logic [31:0]      mem_alu,
  input  logic [31:0]      mem_rdata,
  input  logic [2:0]       mem_ltype,
  input  logic             stall,
  input  logic             flush,
  output logic             wb_valid,
  output logic             wb_we,
  output logic [4:0]       wb_reg,
  output logic [31:0]      wb_data,
  output logic [31:0]      wb_pc,
  output logic [31:0]      wb_ins,
  output logic             fwd_hit,
  output logic             addr_err,
  output logic             addr_err_sticky,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    LT_NONE = 3'b000,
    LT_LB   = 3'b001,
    LT_LBU  = 3'b010,
    LT_LH   = 3'b011,
    LT_LHU  = 3'b100,
    LT_LW   = 3'b101
  } ltype_t;

  logic [1:0]  byte_addr;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] fmt_data;
  logic        misaligned;
  logic        load_err;

  assign byte_addr = mem_alu[1:0];
  assign byte_lane = mem_rdata[{byte_addr, 3'b000} +: 8];
  assign half_lane = byte_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign load_err  = mem_valid & misaligned;

  // Select and extend load data from the read word; non-loads pass the ALU result
  always_comb begin
    fmt_data   = mem_alu;
    misaligned = 1'b0;
    case (ltype_t'(mem_ltype))
      LT_LB:  fmt_data = {{24{byte_lane[7]}}, byte_lane};
      LT_LBU: fmt_data = {24'h000000, byte_lane};
      LT_LH: begin
        misaligned = byte_addr[0];
        fmt_data   = {{16{half_lane[15]}}, half_lane};
      end
      LT_LHU: begin
        misaligned = byte_addr[0];
        fmt_data   = {16'h0000, half_lane};
      end
      LT_LW: begin
        misaligned = (byte_addr != 2'b00);
        fmt_data   = mem_rdata;
      end
      default: fmt_data = mem_alu;
    endcase
    if (misaligned) begin
      fmt_data = 32'h0;
    end
  end

  // Pipeline register: flush zeroes the stage, stall holds fields but retires nothing
  always_ff @(posedge clk) begin
    if (Reset) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_reg   <= 5'd0;
      wb_data  <= 32'h0;
      wb_pc    <= 32'h0;
      wb_ins   <= 32'h0;
      addr_err <= 1'b0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_reg   <= 5'd0;
      wb_data  <= 32'h0;
      wb_pc    <= 32'h0;
      wb_ins   <= 32'h0;
      addr_err <= 1'b0;
    end else if (stall) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      wb_valid <= mem_valid;
      wb_we    <= mem_valid & mem_we & ~misaligned;
      wb_reg   <= mem_dst;
      wb_data  <= fmt_data;
      wb_pc    <= mem_pc;
      wb_ins   <= mem_ins;
      addr_err <= load_err;
    end
  end

  // Sticky error flag: set by any misaligned load that enters the stage, cleared only by reset
  always_ff @(posedge clk) begin
    if (Reset) begin
      addr_err_sticky <= 1'b0;
    end else if (!flush && !stall && load_err) begin
      addr_err_sticky <= 1'b1;
    end
  end

  // Count retired instructions; wraps naturally at the counter width
  always_ff @(posedge clk) begin
    if (Reset) begin
      retire_cnt <= '0;
    end else if (wb_valid) begin
      retire_cnt <= retire_cnt + 1'b1;
    end
  end

  assign fwd_hit = wb_we && (wb_reg != 5'd0);

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table of single-cycle vectors plus
// hand-written reset, stall/flush and counter-wrap sequences.
module tb_wb_stage;

  localparam int CNT_W = 3;

  logic             clk;
  logic             Reset;
  logic             mem_valid;
  logic [31:0]      mem_pc;
  logic [31:0]      mem_ins;
  logic             mem_we;
  logic [4:0]       mem_dst;
  logic [31:0]      mem_alu;
  logic [31:0]      mem_rdata;
  logic [2:0]       mem_ltype;
  logic             stall;
  logic             flush;
  logic             wb_valid;
  logic             wb_we;
  logic [4:0]       wb_reg;
  logic [31:0]      wb_data;
  logic [31:0]      wb_pc;
  logic [31:0]      wb_ins;
  logic             fwd_hit;
  logic             addr_err;
  logic             addr_err_sticky;
  logic [CNT_W-1:0] retire_cnt;

  int errors = 0;
  int checks = 0;

  wb_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .Reset(Reset),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_ins(mem_ins), .mem_we(mem_we),
    .mem_dst(mem_dst), .mem_alu(mem_alu), .mem_rdata(mem_rdata), .mem_ltype(mem_ltype),
    .stall(stall), .flush(flush),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .wb_pc(wb_pc), .wb_ins(wb_ins), .fwd_hit(fwd_hit), .addr_err(addr_err),
    .addr_err_sticky(addr_err_sticky), .retire_cnt(retire_cnt)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic        we;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [2:0]  ltype;
    logic [31:0] pc;
    logic        exp_valid;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        exp_fwd;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive MEM inputs after the falling edge, then step one rising edge and settle
  task automatic applyStimulus(input logic rst, input logic fl, input logic st,
                               input logic valid, input logic we, input logic [4:0] dst,
                               input logic [31:0] alu, input logic [31:0] rdata,
                               input logic [2:0] ltype, input logic [31:0] pc);
    @(negedge clk);
    Reset     = rst;
    flush     = fl;
    stall     = st;
    mem_valid = valid;
    mem_we    = we;
    mem_dst   = dst;
    mem_alu   = alu;
    mem_rdata = rdata;
    mem_ltype = ltype;
    mem_pc    = pc;
    mem_ins   = pc ^ 32'hA5A5_0000;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(wb_valid), 32'h0);
    checkOutput({tag, "_we"}, 32'(wb_we), 32'h0);
    checkOutput({tag, "_reg"}, 32'(wb_reg), 32'h0);
    checkOutput({tag, "_data"}, wb_data, 32'h0);
    checkOutput({tag, "_pc"}, wb_pc, 32'h0);
    checkOutput({tag, "_ins"}, wb_ins, 32'h0);
    checkOutput({tag, "_fwd"}, 32'(fwd_hit), 32'h0);
    checkOutput({tag, "_err"}, 32'(addr_err), 32'h0);
    checkOutput({tag, "_sticky"}, 32'(addr_err_sticky), 32'h0);
    checkOutput({tag, "_cnt"}, 32'(retire_cnt), 32'h0);
  endtask

  initial begin
    int          exp_cnt;
    logic        exp_sticky;
    logic [31:0] rd;

    rd = 32'h80FF_7F01;
    //         name        v  we dst alu           rdata ltype pc            ev ewe edata          err fwd
    vecs[0]  = '{"alu",    1, 1, 8, 32'h1234ABCD, rd, 3'd0, 32'h3004, 1, 1, 32'h1234ABCD, 0, 1};
    vecs[1]  = '{"lb_a3",  1, 1, 9, 32'h00001003, rd, 3'd1, 32'h3008, 1, 1, 32'hFFFFFF80, 0, 1};
    vecs[2]  = '{"lbu_a1", 1, 1, 9, 32'h00001001, rd, 3'd2, 32'h300C, 1, 1, 32'h0000007F, 0, 1};
    vecs[3]  = '{"lbu_a2", 1, 1, 9, 32'h00001002, rd, 3'd2, 32'h3010, 1, 1, 32'h000000FF, 0, 1};
    vecs[4]  = '{"lh_a2",  1, 1, 10, 32'h00001002, rd, 3'd3, 32'h3014, 1, 1, 32'hFFFF80FF, 0, 1};
    vecs[5]  = '{"lhu_a0", 1, 1, 10, 32'h00001000, rd, 3'd4, 32'h3018, 1, 1, 32'h00007F01, 0, 1};
    vecs[6]  = '{"lhu_a2", 1, 1, 10, 32'h00001002, rd, 3'd4, 32'h301C, 1, 1, 32'h000080FF, 0, 1};
    vecs[7]  = '{"lw_a0",  1, 1, 11, 32'h00001000, rd, 3'd5, 32'h3020, 1, 1, 32'h80FF7F01, 0, 1};
    vecs[8]  = '{"lh_mis", 1, 1, 11, 32'h00001001, rd, 3'd3, 32'h3024, 1, 0, 32'h00000000, 1, 0};
    vecs[9]  = '{"lw_mis", 1, 1, 12, 32'h00001002, rd, 3'd5, 32'h3028, 1, 0, 32'h00000000, 1, 0};
    vecs[10] = '{"lb_a0",  1, 1, 12, 32'h00001000, rd, 3'd1, 32'h302C, 1, 1, 32'h00000001, 0, 1};
    vecs[11] = '{"dst0",   1, 1, 0, 32'h00000077, rd, 3'd0, 32'h3030, 1, 1, 32'h00000077, 0, 0};
    vecs[12] = '{"invalid", 0, 1, 13, 32'h00000099, rd, 3'd0, 32'h3034, 0, 0, 32'h00000099, 0, 0};
    vecs[13] = '{"ltype6", 1, 1, 14, 32'h00001003, rd, 3'd6, 32'h3038, 1, 1, 32'h00001003, 0, 1};

    // Reset from power-up
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 3, 32'h5, rd, 3'd0, 32'h44);
    checkAllZero("reset");

    exp_cnt    = 0;
    exp_sticky = 1'b0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(0, 0, 0, vecs[i].valid, vecs[i].we, vecs[i].dst, vecs[i].alu,
                    vecs[i].rdata, vecs[i].ltype, vecs[i].pc);
      exp_sticky = exp_sticky | vecs[i].exp_err;
      checkOutput({vecs[i].name, "_valid"}, 32'(wb_valid), 32'(vecs[i].exp_valid));
      checkOutput({vecs[i].name, "_we"}, 32'(wb_we), 32'(vecs[i].exp_we));
      checkOutput({vecs[i].name, "_data"}, wb_data, vecs[i].exp_data);
      checkOutput({vecs[i].name, "_reg"}, 32'(wb_reg), 32'(vecs[i].dst));
      checkOutput({vecs[i].name, "_pc"}, wb_pc, vecs[i].pc);
      checkOutput({vecs[i].name, "_ins"}, wb_ins, vecs[i].pc ^ 32'hA5A5_0000);
      checkOutput({vecs[i].name, "_err"}, 32'(addr_err), 32'(vecs[i].exp_err));
      checkOutput({vecs[i].name, "_fwd"}, 32'(fwd_hit), 32'(vecs[i].exp_fwd));
      checkOutput({vecs[i].name, "_sticky"}, 32'(addr_err_sticky), 32'(exp_sticky));
      checkOutput({vecs[i].name, "_cnt"}, 32'(retire_cnt), exp_cnt % 8);
      if (vecs[i].exp_valid) exp_cnt++;
    end

    // Capture dst=5, then stall holds fields without retiring
    applyStimulus(0, 0, 0, 1, 1, 5, 32'h55, rd, 3'd0, 32'h5004);
    checkOutput("cap_reg", 32'(wb_reg), 32'd5);
    checkOutput("cap_valid", 32'(wb_valid), 32'd1);
    checkOutput("cap_cnt", 32'(retire_cnt), exp_cnt % 8);
    exp_cnt++;
    applyStimulus(0, 0, 1, 1, 1, 7, 32'h66, rd, 3'd5, 32'h6004);
    checkOutput("stall_valid", 32'(wb_valid), 32'd0);
    checkOutput("stall_we", 32'(wb_we), 32'd0);
    checkOutput("stall_reg", 32'(wb_reg), 32'd5);
    checkOutput("stall_data", wb_data, 32'h55);
    checkOutput("stall_pc", wb_pc, 32'h5004);
    checkOutput("stall_fwd", 32'(fwd_hit), 32'd0);
    checkOutput("stall_cnt", 32'(retire_cnt), exp_cnt % 8);

    // Flush beats stall and ignores a misaligned incoming load
    applyStimulus(0, 1, 1, 1, 1, 7, 32'h1002, rd, 3'd5, 32'h6004);
    checkOutput("flush_reg", 32'(wb_reg), 32'd0);
    checkOutput("flush_pc", wb_pc, 32'h0);
    checkOutput("flush_data", wb_data, 32'h0);
    checkOutput("flush_ins", wb_ins, 32'h0);
    checkOutput("flush_valid", 32'(wb_valid), 32'd0);
    checkOutput("flush_err", 32'(addr_err), 32'd0);
    checkOutput("flush_sticky", 32'(addr_err_sticky), 32'd1);
    checkOutput("flush_cnt", 32'(retire_cnt), exp_cnt % 8);

    // Misaligned LW: one-cycle error pulse, still retires
    applyStimulus(0, 0, 0, 1, 1, 4, 32'h1002, rd, 3'd5, 32'h7004);
    checkOutput("mis_err", 32'(addr_err), 32'd1);
    checkOutput("mis_we", 32'(wb_we), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, rd, 3'd0, 32'h0);
    checkOutput("mis_err_clr", 32'(addr_err), 32'd0);
    checkOutput("mis_sticky", 32'(addr_err_sticky), 32'd1);
    checkOutput("mis_cnt", 32'(retire_cnt), (exp_cnt + 1) % 8);

    // Mid-stream reset, asserted together with flush and a valid input
    applyStimulus(1, 1, 0, 1, 1, 6, 32'h1234, rd, 3'd0, 32'h8004);
    checkAllZero("midreset");

    // Counter wrap: nine retirements on a 3-bit counter leave it at 1
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 5'(i + 1), 32'(i), rd, 3'd0, 32'(4 * i + 4));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, rd, 3'd0, 32'h0);
    checkOutput("wrap_cnt", 32'(retire_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
